// File: rtl/demux1t8_32_wr_if.sv
// Write-side bus for the 1-to-8 distributor: request handshake plus the eight held channel outputs.
interface demux1t8_32_wr_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  s;
    logic [31:0] din;
    logic [3:0]  be;
    logic        bcast;
    logic [31:0] O0, O1, O2, O3, O4, O5, O6, O7;
    logic [7:0]  upd;
    logic        busy;

    modport master (
        output in_valid, s, din, be, bcast,
        input  in_ready, O0, O1, O2, O3, O4, O5, O6, O7, upd, busy
    );

    modport slave (
        input  in_valid, s, din, be, bcast,
        output in_ready, O0, O1, O2, O3, O4, O5, O6, O7, upd, busy
    );
endinterface

// File: rtl/demux1t8_32_wr.sv
// 1-to-8 registered write distributor with byte-enable merge and sequential broadcast.
module demux1t8_32_wr #(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst,
    demux1t8_32_wr_if.slave  bus
);

    typedef enum logic {IDLE, BCAST} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic [2:0]  r_cnt;
    logic [31:0] r_bd;
    logic [3:0]  r_bbe;
    logic [31:0] r_o [0:7];
    logic [7:0]  r_upd;

    function automatic logic [31:0] f_merge(input logic [31:0] i_old,
                                            input logic [31:0] i_new,
                                            input logic [3:0]  i_be);
        f_merge = i_old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i_be[i]) f_merge[8*i +: 8] = i_new[8*i +: 8];
        end
    endfunction

    always_comb begin
        w_next_state = r_state;
        w_accept     = bus.in_valid & (r_state == IDLE);
        case (r_state)
            IDLE:    if (w_accept && bus.bcast) w_next_state = BCAST;
            BCAST:   if (r_cnt == 3'd7)         w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < 8; k++) r_o[k] <= RST_VAL;
            r_upd <= '0;
            r_cnt <= '0;
            r_bd  <= '0;
            r_bbe <= '0;
        end else begin
            r_upd <= '0;
            if (r_state == BCAST) begin
                // cnt wraps 7 -> 0 on the final write, matching the return to IDLE
                r_o[r_cnt] <= f_merge(r_o[r_cnt], r_bd, r_bbe);
                r_upd      <= 8'd1 << r_cnt;
                r_cnt      <= r_cnt + 3'd1;
            end else if (w_accept) begin
                if (bus.bcast) begin
                    r_bd  <= bus.din;
                    r_bbe <= bus.be;
                    r_cnt <= '0;
                end else begin
                    r_o[bus.s] <= f_merge(r_o[bus.s], bus.din, bus.be);
                    r_upd      <= 8'd1 << bus.s;
                end
            end
        end
    end

    assign bus.in_ready = (r_state == IDLE);
    assign bus.busy     = (r_state == BCAST);
    assign bus.upd      = r_upd;
    assign bus.O0       = r_o[0];
    assign bus.O1       = r_o[1];
    assign bus.O2       = r_o[2];
    assign bus.O3       = r_o[3];
    assign bus.O4       = r_o[4];
    assign bus.O5       = r_o[5];
    assign bus.O6       = r_o[6];
    assign bus.O7       = r_o[7];

endmodule

// File: tb/tb_demux1t8_32_wr.sv
// Directed bench for demux1t8_32_wr: vector table for single writes, hand sequences for broadcast and reset.
module tb_demux1t8_32_wr;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    demux1t8_32_wr_if bus();

    demux1t8_32_wr #(.RST_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  s;
        logic [31:0] din;
        logic [3:0]  be;
        logic [31:0] exp_o;
        logic [7:0]  exp_upd;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] exp_all [8];

    function automatic logic [31:0] get_o(input int k);
        case (k)
            0: return bus.O0;
            1: return bus.O1;
            2: return bus.O2;
            3: return bus.O3;
            4: return bus.O4;
            5: return bus.O5;
            6: return bus.O6;
            default: return bus.O7;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all_rst(input string name);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_O%0d", name, k), get_o(k), RV);
        chk({name, "_upd"},   {24'd0, bus.upd}, 32'd0);
        chk({name, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({name, "_busy"},  {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{3'd3, 32'h0000_0000, 4'hF, 32'h0000_0000, 8'h08};
        vecs[1] = '{3'd3, 32'h1122_3344, 4'h5, 32'h0022_0044, 8'h08};
        vecs[2] = '{3'd0, 32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5, 8'h01};
        vecs[3] = '{3'd7, 32'h0000_0000, 4'hF, 32'h0000_0000, 8'h80};
        vecs[4] = '{3'd7, 32'h0000_00FF, 4'h1, 32'h0000_00FF, 8'h80};
        vecs[5] = '{3'd1, 32'h1234_5678, 4'hC, 32'h1234_BEEF, 8'h02};
        vecs[6] = '{3'd6, 32'hFFFF_FFFF, 4'h0, 32'hDEAD_BEEF, 8'h40};
        vecs[7] = '{3'd5, 32'h0000_AB00, 4'h2, 32'hDEAD_ABEF, 8'h20};

        exp_all = '{32'hA5A5_A5A5, 32'h1234_BEEF, 32'hDEAD_BEEF, 32'h0022_0044,
                    32'hDEAD_BEEF, 32'hDEAD_ABEF, 32'hDEAD_BEEF, 32'h0000_00FF};

        bus.in_valid = 1'b0;
        bus.s        = '0;
        bus.din      = '0;
        bus.be       = '0;
        bus.bcast    = 1'b0;
        rst          = 1'b0;

        // asynchronous reset mid-cycle, checked before any clock edge
        #2 rst = 1'b1;
        #1 chk_all_rst("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // back-to-back table writes, valid held high throughout
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.bcast    = 1'b0;
            bus.s        = vecs[i].s;
            bus.din      = vecs[i].din;
            bus.be       = vecs[i].be;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_upd", i), {24'd0, bus.upd}, {24'd0, vecs[i].exp_upd});
            chk($sformatf("vec%0d_O", i), get_o(int'(vecs[i].s)), vecs[i].exp_o);
            chk($sformatf("vec%0d_ready", i), {31'd0, bus.in_ready}, 32'd1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_upd", {24'd0, bus.upd}, 32'd0);
        for (int k = 0; k < 8; k++) chk($sformatf("table_O%0d", k), get_o(k), exp_all[k]);

        // broadcast with a conflicting request held pending
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.bcast    = 1'b1;
        bus.din      = 32'hCAFE_F00D;
        bus.be       = 4'hF;
        bus.s        = 3'd5;
        @(posedge clk); #1;
        chk("bc_accept_upd",   {24'd0, bus.upd}, 32'd0);
        chk("bc_accept_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bc_accept_busy",  {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.bcast = 1'b0;
        bus.s     = 3'd2;
        bus.din   = 32'h0000_0000;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] w;
            w = 8'd1 << k;
            @(posedge clk); #1;
            chk($sformatf("bc%0d_upd", k), {24'd0, bus.upd}, {24'd0, w});
            chk($sformatf("bc%0d_O", k), get_o(k), 32'hCAFE_F00D);
            chk($sformatf("bc%0d_ready", k), {31'd0, bus.in_ready}, (k == 7) ? 32'd1 : 32'd0);
            chk($sformatf("bc%0d_busy", k),  {31'd0, bus.busy},     (k == 7) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        chk("bc_pending_upd", {24'd0, bus.upd}, 32'h04);
        chk("bc_pending_O2",  bus.O2, 32'd0);
        @(negedge clk) bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++)
            if (k != 2) chk($sformatf("bc_final_O%0d", k), get_o(k), 32'hCAFE_F00D);

        // reset in the middle of a broadcast
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.bcast    = 1'b1;
        bus.din      = 32'h1234_5678;
        bus.be       = 4'hF;
        @(posedge clk);
        @(negedge clk) bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_upd3", {24'd0, bus.upd}, 32'h08);
        chk("mid_O3",   bus.O3, 32'h1234_5678);
        #2 rst = 1'b1;
        #1 chk_all_rst("mid_reset");
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.bcast    = 1'b0;
        bus.s        = 3'd4;
        bus.din      = 32'h0000_0000;
        bus.be       = 4'hF;
        @(posedge clk); #1;
        chk("post_rst_upd", {24'd0, bus.upd}, 32'h10);
        chk("post_rst_O4",  bus.O4, 32'd0);
        @(negedge clk) bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_idle_upd", {24'd0, bus.upd}, 32'd0);
        chk("post_rst_busy",     {31'd0, bus.busy}, 32'd0);
        for (int k = 5; k < 8; k++) chk($sformatf("post_rst_O%0d", k), get_o(k), RV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
